// File: rtl/load_response_aligner_pkg.sv
// Load-path types shared by the response aligner: attribute, FP-op and writeback packet formats.
// Mirrors the cva5_types / cva5_config definitions so this slice builds stand-alone.
package load_response_aligner_pkg;
  localparam int FLEN            = 64;
  localparam int NUM_SUB_UNITS_W = 2;
  localparam int ID_W            = 4;

  typedef logic [ID_W-1:0] id_t;

  typedef enum logic [1:0] {
    INT_DONE    = 2'd0,
    SINGLE_DONE = 2'd1,
    DOUBLE_HOLD = 2'd2,
    DOUBLE_DONE = 2'd3
  } fp_ls_op_t;

  typedef struct packed {
    id_t                        id;
    logic [1:0]                 byte_addr;
    logic [1:0]                 final_mux_sel;
    logic [1:0]                 sign_sel;
    logic                       is_signed;
    logic [NUM_SUB_UNITS_W-1:0] subunit_id;
    fp_ls_op_t                  fp_op;
  } load_attributes_t;

  typedef struct packed {
    id_t         id;
    logic        valid;
    logic [31:0] data;
  } wb_packet_t;

  typedef struct packed {
    id_t             id;
    logic            valid;
    logic [FLEN-1:0] data;
  } fp_wb_packet_t;
endpackage

// File: rtl/load_response_aligner_attr_fifo.sv
// In-order load-attribute FIFO; a push when full is accepted only if a pop frees the slot
// in the same cycle. Head is visible combinationally, with no push-to-pop bypass.
module load_attr_fifo
  import load_response_aligner_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  load_attributes_t i_data,
  output load_attributes_t o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  load_attributes_t r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/load_response_aligner.sv
// Matches sub-unit load responses to queued attributes, aligns/sign-extends, registers writeback (1 cycle).
// Stalls the head sub-unit while an unacked packet is held; LOAD_RESPONSE_FP_EN adds FP NaN-box/double paths.
module load_response_aligner
  import load_response_aligner_pkg::*;
#(
  parameter int NUM_SUB_UNITS = 3,
  parameter int ATTR_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           attr_push,
  input  load_attributes_t               attr_in,
  output logic                           attr_full,
  input  logic [NUM_SUB_UNITS-1:0]       sub_valid,
  input  logic [NUM_SUB_UNITS-1:0][31:0] sub_data,
  output logic [NUM_SUB_UNITS-1:0]       sub_ready,
  output wb_packet_t                     wb_out,
  output fp_wb_packet_t                  fp_wb_out,
  input  logic                           wb_ack,
  output logic                           protocol_error
);
  load_attributes_t w_head;
  logic             w_empty;
  logic             w_full;
  logic             w_match;
  logic             w_stray;
  logic             w_pop;
  logic             w_out_free;
  logic             w_fp_vld;
  logic [31:0]      w_word;
  logic [31:0]      w_shifted;
  logic [31:0]      w_int_data;
  logic             w_sign;
  wb_packet_t       r_wb;
  logic             r_perr;

  load_attr_fifo #(.DEPTH(ATTR_DEPTH)) u_attr_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (attr_push),
    .i_pop   (w_pop),
    .i_data  (attr_in),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_match = 1'b0;
    w_stray = 1'b0;
    w_word  = '0;
    for (int i = 0; i < NUM_SUB_UNITS; i++) begin
      if (!w_empty && (w_head.subunit_id == NUM_SUB_UNITS_W'(i))) begin
        w_match = sub_valid[i];
        w_word  = sub_data[i];
      end else if (sub_valid[i]) begin
        w_stray = 1'b1;
      end
    end
  end

  assign w_out_free = !(r_wb.valid || w_fp_vld) || wb_ack;
  assign w_pop      = w_match && w_out_free;

  always_comb begin
    sub_ready = '0;
    for (int i = 0; i < NUM_SUB_UNITS; i++) begin
      sub_ready[i] = w_pop && (w_head.subunit_id == NUM_SUB_UNITS_W'(i));
    end
  end

  // Sign bit comes from the unshifted word so sign_sel is independent of byte_addr.
  assign w_shifted = w_word >> {w_head.byte_addr, 3'b000};
  assign w_sign    = w_head.is_signed && !w_head.final_mux_sel[1] &&
                     w_word[{w_head.sign_sel, 3'b111}];

  always_comb begin
    case (w_head.final_mux_sel)
      2'd0:    w_int_data = {{24{w_sign}}, w_shifted[7:0]};
      2'd1:    w_int_data = {{16{w_sign}}, w_shifted[15:0]};
      default: w_int_data = w_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perr <= 1'b0;
    end else if (w_stray || (attr_push && w_full && !w_pop)) begin
      r_perr <= 1'b1;
    end
  end

`ifdef LOAD_RESPONSE_FP_EN
  fp_wb_packet_t r_fp_wb;
  logic [31:0]   r_held;

  assign w_fp_vld = r_fp_wb.valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb    <= '0;
      r_fp_wb <= '0;
      r_held  <= '0;
    end else begin
      if (wb_ack) begin
        r_wb.valid    <= 1'b0;
        r_fp_wb.valid <= 1'b0;
      end
      if (w_pop) begin
        case (w_head.fp_op)
          INT_DONE: begin
            r_wb          <= {w_head.id, 1'b1, w_int_data};
            r_fp_wb.valid <= 1'b0;
          end
          SINGLE_DONE: begin
            r_fp_wb    <= {w_head.id, 1'b1, 32'hFFFF_FFFF, w_word};
            r_wb.valid <= 1'b0;
          end
          DOUBLE_HOLD: r_held <= w_word;
          default: begin
            r_fp_wb    <= {w_head.id, 1'b1, w_word, r_held};
            r_wb.valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fp_wb_out = r_fp_wb;
`else
  logic w_unused_fp_op;

  assign w_fp_vld       = 1'b0;
  assign w_unused_fp_op = ^w_head.fp_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb <= '0;
    end else if (w_pop) begin
      r_wb <= {w_head.id, 1'b1, w_int_data};
    end else if (wb_ack) begin
      r_wb.valid <= 1'b0;
    end
  end

  assign fp_wb_out = '0;
`endif

  assign attr_full      = w_full;
  assign wb_out         = r_wb;
  assign protocol_error = r_perr;
endmodule

// File: tb/tb_load_response_aligner.sv
// Randomized + directed bench for load_response_aligner against a queue-based reference model.
module tb_load_response_aligner;
  import load_response_aligner_pkg::*;

  localparam int NSU   = 3;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 attr_push;
  load_attributes_t     attr_in;
  logic                 attr_full;
  logic [NSU-1:0]       sub_valid;
  logic [NSU-1:0][31:0] sub_data;
  logic [NSU-1:0]       sub_ready;
  wb_packet_t           wb_out;
  fp_wb_packet_t        fp_wb_out;
  logic                 wb_ack;
  logic                 protocol_error;

  always #5 clk = ~clk;

  load_response_aligner #(.NUM_SUB_UNITS(NSU), .ATTR_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .attr_push      (attr_push),
    .attr_in        (attr_in),
    .attr_full      (attr_full),
    .sub_valid      (sub_valid),
    .sub_data       (sub_data),
    .sub_ready      (sub_ready),
    .wb_out         (wb_out),
    .fp_wb_out      (fp_wb_out),
    .wb_ack         (wb_ack),
    .protocol_error (protocol_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Reference model state
  load_attributes_t q[$];
  logic        m_vi, m_vf, m_perr;
  id_t         m_id;
  logic [31:0] m_data, m_held;
  logic [63:0] m_fp;

  function automatic logic [31:0] fmt(input load_attributes_t a, input logic [31:0] w);
    logic [31:0] v;
    logic [31:0] mask;
    int nbits;
    v = w >> (8 * a.byte_addr);
    nbits = (a.final_mux_sel == 2'd0) ? 8 : (a.final_mux_sel == 2'd1) ? 16 : 32;
    if (nbits < 32) begin
      mask = (32'h1 << nbits) - 32'h1;
      v = v & mask;
      if (a.is_signed && w[8 * a.sign_sel + 7]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic load_attributes_t mk(input int id, input int ba, input int ms, input int ss,
                                          input int sg, input int su, input int op);
    load_attributes_t a;
    a.id            = id_t'(id);
    a.byte_addr     = 2'(ba);
    a.final_mux_sel = 2'(ms);
    a.sign_sel      = 2'(ss);
    a.is_signed     = 1'(sg);
    a.subunit_id    = NUM_SUB_UNITS_W'(su);
    a.fp_op         = fp_ls_op_t'(op);
    return a;
  endfunction

  task automatic check_outputs();
    check("wb_valid", 64'(wb_out.valid), 64'(m_vi));
    check("perr", 64'(protocol_error), 64'(m_perr));
    if (m_vi) begin
      check("wb_id", 64'(wb_out.id), 64'(m_id));
      check("wb_data", 64'(wb_out.data), 64'(m_data));
    end
`ifdef LOAD_RESPONSE_FP_EN
    check("fp_valid", 64'(fp_wb_out.valid), 64'(m_vf));
    if (m_vf) begin
      check("fp_id", 64'(fp_wb_out.id), 64'(m_id));
      check("fp_data", fp_wb_out.data, m_fp);
    end
`else
    check("fp_tied", 64'(fp_wb_out[FLEN:0]), 64'd0);
`endif
  endtask

  // One cycle, entered and left at posedge+1.
  task automatic step(input logic push, input load_attributes_t a, input logic [NSU-1:0] sv,
                      input logic [NSU-1:0][31:0] d, input logic ack);
    logic free, full, pop, stray;
    logic [NSU-1:0] exp_rdy;
    load_attributes_t h;
    fp_ls_op_t op;
    attr_push = push; attr_in = a; sub_valid = sv; sub_data = d; wb_ack = ack;
    free = !(m_vi || m_vf) || ack;
    full = (q.size() == DEPTH);
    pop = 1'b0; stray = 1'b0; exp_rdy = '0;
    for (int i = 0; i < NSU; i++) begin
      if (sv[i]) begin
        if (q.size() == 0 || int'(q[0].subunit_id) != i) stray = 1'b1;
        else if (free) pop = 1'b1;
      end
    end
    if (pop) exp_rdy[q[0].subunit_id] = 1'b1;
    #3;
    check("sub_ready", 64'(sub_ready), 64'(exp_rdy));
    check("attr_full", 64'(attr_full), 64'(full));
    @(posedge clk);
    if (ack) begin m_vi = 1'b0; m_vf = 1'b0; end
    if (pop) begin
      h = q.pop_front();
`ifdef LOAD_RESPONSE_FP_EN
      op = h.fp_op;
`else
      op = INT_DONE;
`endif
      case (op)
        INT_DONE:    begin m_vi = 1'b1; m_vf = 1'b0; m_id = h.id; m_data = fmt(h, d[h.subunit_id]); end
        SINGLE_DONE: begin m_vf = 1'b1; m_vi = 1'b0; m_id = h.id; m_fp = {32'hFFFF_FFFF, d[h.subunit_id]}; end
        DOUBLE_HOLD: m_held = d[h.subunit_id];
        default:     begin m_vf = 1'b1; m_vi = 1'b0; m_id = h.id; m_fp = {d[h.subunit_id], m_held}; end
      endcase
    end
    if (push) begin
      if (!full || pop) q.push_back(a);
      else m_perr = 1'b1;
    end
    if (stray) m_perr = 1'b1;
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic ack);
    step(1'b0, '0, '0, '0, ack);
  endtask

  task automatic respond(input int su, input logic [31:0] w, input logic ack);
    logic [NSU-1:0] sv;
    logic [NSU-1:0][31:0] d;
    sv = '0; d = '0;
    sv[su] = 1'b1; d[su] = w;
    step(1'b0, '0, sv, d, ack);
  endtask

  // Entered at posedge+1; reset asserts mid-cycle, left at posedge+1 after release.
  task automatic do_reset();
    #1 rst = 1'b0;
    #1;
    check("rst_wb", 64'(wb_out), 64'd0);
    check("rst_fp", fp_wb_out[63:0], 64'd0);
    check("rst_ready", 64'(sub_ready), 64'd0);
    check("rst_full", 64'(attr_full), 64'd0);
    check("rst_perr", 64'(protocol_error), 64'd0);
    attr_push = 1'b0; sub_valid = '0; wb_ack = 1'b0; attr_in = '0; sub_data = '0;
    q.delete();
    m_vi = 1'b0; m_vf = 1'b0; m_perr = 1'b0; m_id = '0; m_data = '0; m_held = '0; m_fp = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic rand_cycle(input bit allow_stray);
    load_attributes_t a;
    logic [NSU-1:0] sv;
    logic [NSU-1:0][31:0] d;
    a = mk($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, NSU-1), $urandom_range(0, 3));
    sv = '0;
    if (q.size() > 0 && $urandom_range(0, 99) < 60) sv[q[0].subunit_id] = 1'b1;
    if (allow_stray && $urandom_range(0, 99) < 5) sv[$urandom_range(0, NSU-1)] = 1'b1;
    for (int i = 0; i < NSU; i++) d[i] = $urandom;
    step(1'($urandom_range(0, 99) < 45), a, sv, d, 1'($urandom_range(0, 99) < 70));
  endtask

  initial begin
    rst = 1'b1; attr_push = 1'b0; attr_in = '0; sub_valid = '0; sub_data = '0; wb_ack = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Byte / halfword alignment and sign extension
    step(1'b1, mk(3, 2, 0, 2, 1, 1, 0), '0, '0, 1'b0);
    respond(1, 32'h0080_0000, 1'b0);
    check("byte_signed", 64'(wb_out), 64'({4'd3, 1'b1, 32'hFFFF_FF80}));
    step(1'b1, mk(5, 2, 0, 2, 0, 1, 0), '0, '0, 1'b1);
    respond(1, 32'h0080_0000, 1'b0);
    check("byte_unsigned", 64'(wb_out.data), 64'h0000_0080);
    step(1'b1, mk(6, 2, 1, 3, 1, 0, 0), '0, '0, 1'b1);
    respond(0, 32'h8001_0000, 1'b1);
    check("half_signed", 64'(wb_out.data), 64'hFFFF_8001);
    idle(1'b1);

    // Fill, overflow push, back-to-back drain
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, mk(4 + k, 0, 2, 0, 0, k % NSU, 0), '0, '0, 1'b0);
    check("full_after_4", 64'(attr_full), 64'd1);
    step(1'b1, mk(9, 0, 2, 0, 0, 0, 0), '0, '0, 1'b0);
    check("overflow_perr", 64'(protocol_error), 64'd1);
    for (int k = 0; k < 4; k++) begin
      respond(k % NSU, 32'hA000_0000 + 32'(k), 1'b1);
      check("drain_id", 64'(wb_out.id), 64'(4 + k));
      check("drain_valid", 64'(wb_out.valid), 64'd1);
    end
    idle(1'b1);

    // Wrong sub-unit, then backpressure
    do_reset();
    step(1'b1, mk(1, 0, 2, 0, 0, 0, 0), '0, '0, 1'b0);
    respond(2, 32'hDEAD_BEEF, 1'b0);
    check("stray_perr", 64'(protocol_error), 64'd1);
    check("stray_nopkt", 64'(wb_out.valid), 64'd0);
    respond(0, 32'h1234_5678, 1'b0);
    step(1'b1, mk(2, 0, 2, 0, 0, 0, 0), '0, '0, 1'b0);
    respond(0, 32'h0BAD_F00D, 1'b0);
    check("stall_hold_id", 64'(wb_out.id), 64'd1);
    respond(0, 32'h0BAD_F00D, 1'b1);
    check("after_ack_id", 64'(wb_out.id), 64'd2);

    // Reset with entries queued and a packet pending
    step(1'b1, mk(7, 0, 2, 0, 0, 1, 0), '0, '0, 1'b1);
    step(1'b1, mk(8, 0, 2, 0, 0, 2, 0), '0, '0, 1'b0);
    step(1'b1, mk(9, 0, 2, 0, 0, 0, 0), '0, '0, 1'b0);
    respond(1, 32'h5555_AAAA, 1'b0);
    check("pre_rst_valid", 64'(wb_out.valid), 64'd1);
    do_reset();
    respond(2, 32'h1, 1'b0);
    check("post_rst_perr", 64'(protocol_error), 64'd1);
    check("post_rst_nopkt", 64'(wb_out.valid), 64'd0);

`ifdef LOAD_RESPONSE_FP_EN
    do_reset();
    step(1'b1, mk(1, 0, 0, 0, 1, 0, 2), '0, '0, 1'b0);
    step(1'b1, mk(2, 0, 0, 0, 1, 1, 3), '0, '0, 1'b0);
    step(1'b1, mk(3, 1, 0, 0, 1, 2, 1), '0, '0, 1'b0);
    respond(0, 32'h1111_1111, 1'b0);
    check("hold_nopkt", 64'(fp_wb_out.valid), 64'd0);
    respond(1, 32'h2222_2222, 1'b0);
    check("double_data", fp_wb_out.data, 64'h2222_2222_1111_1111);
    respond(2, 32'h3F80_0000, 1'b1);
    check("single_data", fp_wb_out.data, 64'hFFFF_FFFF_3F80_0000);
    idle(1'b1);
`endif

    do_reset();
    for (int n = 0; n < 400; n++) rand_cycle(1'b0);
    for (int n = 0; n < 400; n++) rand_cycle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/load_response_aligner.md
LOAD_RESPONSE_ALIGNER -- requirements
Module: load_response_aligner

Interface
REQ-001 The block SHALL have parameter NUM_SUB_UNITS, default 3: number of load data sub-units returning responses.
REQ-002 The block SHALL have parameter ATTR_DEPTH, default 4, a power of two ≥2: entries in the load-attribute FIFO.
REQ-003 Port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port attr_push, input, 1: enqueues one load_attributes_t.
REQ-006 Port attr_in, input, load_attributes_t: attributes for the load being issued.
REQ-007 Port attr_full, output, 1: the FIFO holds ATTR_DEPTH entries.
REQ-008 Port sub_valid, input, NUM_SUB_UNITS: per-sub-unit response valid.
REQ-009 Port sub_data, input, NUM_SUB_UNITS x 32: per-sub-unit response word.
REQ-010 Port sub_ready, output, NUM_SUB_UNITS: a response is consumed on this sub-unit this cycle.
REQ-011 Port wb_out, output, wb_packet_t: integer writeback packet.
REQ-012 Port fp_wb_out, output, fp_wb_packet_t: FP writeback packet.
REQ-013 Port wb_ack, input, 1: consumer accepts whichever writeback packet is valid.
REQ-014 Port protocol_error, output, 1: sticky protocol violation flag.

Function
REQ-015 The attribute FIFO SHALL be in order; a push when full SHALL be dropped and SHALL set protocol_error; a simultaneous push and pop when full SHALL be legal.
REQ-016 The head entry SHALL pop when sub_valid[head.subunit_id] is high and the output stage is free, meaning neither packet is valid or wb_ack is high.
REQ-017 sub_ready[i] SHALL equal that pop condition for i = head.subunit_id and SHALL be 0 for every other i.
REQ-018 sub_valid on a non-head sub-unit, or any sub_valid while the FIFO is empty, SHALL be ignored and SHALL set protocol_error.
REQ-019 A pushed entry SHALL NOT be matchable in its push cycle; there is no bypass.
REQ-020 Alignment: shifted = data >> (8 × byte_addr).
REQ-021 final_mux_sel SHALL select the result width: 0 → byte, 1 → halfword, 2 or 3 → full word.
REQ-022 The sign bit SHALL be bit 7 of byte lane sign_sel of the unshifted data; it is applied only when is_signed and width < word, otherwise zero-extension is used.
REQ-023 A popped INT_DONE entry SHALL register wb_out = {id, valid=1, formatted data} with one-cycle latency (response at cycle N → valid at N+1).
REQ-024 wb_out and fp_wb_out SHALL hold stable until a cycle with wb_ack high; at most one of them is valid at a time.
REQ-025 Pop and new output in the same cycle as an ack SHALL give back-to-back packets with no bubble.

Reset
REQ-026 While rst is low: FIFO empty, attr_full=0, both packets' valid=0 and data/id=0, sub_ready=0, protocol_error=0, held-low-word register=0.
REQ-027 Reset asserted mid-transfer SHALL discard all pending attributes and any unacknowledged packet.

Configuration
REQ-028 With LOAD_RESPONSE_FP_EN defined, a SINGLE_DONE entry SHALL produce fp_wb_out with data = {32'hFFFFFFFF, word} (NaN-boxed, FLEN=64).
REQ-029 With LOAD_RESPONSE_FP_EN defined, a DOUBLE_HOLD entry SHALL store its word in the held-low register, pop, and produce no packet.
REQ-030 With LOAD_RESPONSE_FP_EN defined, a DOUBLE_DONE entry SHALL produce fp_wb_out with data = {word, held-low}.
REQ-031 For FP ops, alignment and sign extension SHALL be bypassed; the raw word is used.
REQ-032 Without LOAD_RESPONSE_FP_EN, fp_op SHALL be treated as INT_DONE, fp_wb_out SHALL be tied to 0, and the held-low register SHALL be absent.

Structure
REQ-033 load_attributes_t, fp_ls_op_t, wb_packet_t, fp_wb_packet_t, id_t, FLEN and NUM_SUB_UNITS_W SHALL come from the shared cva5_types/cva5_config packages; no new shared types are added.
REQ-034 The attribute FIFO SHALL be a sub-module, load_attr_fifo, with push/pop, full/empty and wrap-around pointers; formatting SHALL be local combinational logic.

Verification
REQ-035 Push {id=3, byte_addr=2, final_mux_sel=0, sign_sel=2, is_signed=1, subunit_id=1}; sub_data[1]=32'h0080_0000 → next cycle wb_out={id 3, valid, 32'hFFFF_FF80}.
REQ-036 Same stimulus with is_signed=0 → data 32'h0000_0080; halfword case byte_addr=2, final_mux_sel=1, data 32'h8001_0000, signed → 32'hFFFF_8001.
REQ-037 Push 4 entries, then a 5th push while attr_full=1 → 5th dropped, protocol_error=1; drain 4 responses in order with wb_ack held high → 4 back-to-back packets, with ids matching push order.
REQ-038 Response on subunit 2 while head expects subunit 0 → sub_ready=0, no packet, protocol_error=1; wb_ack held low with a second response pending → sub_ready=0 until ack.
REQ-039 FP_EN: DOUBLE_HOLD with word 32'h1111_1111, then DOUBLE_DONE with word 32'h2222_2222 → single fp_wb_out data 64'h2222_2222_1111_1111; SINGLE_DONE with word 32'h3F80_0000 → 64'hFFFF_FFFF_3F80_0000.
REQ-040 Assert rst with 2 entries queued and wb_out valid → all outputs 0 asynchronously; after release, a response on the prior head sub-unit is ignored and flags protocol_error.
